// File: rtl/transient_detector.sv
// transient_detector: fast/slow magnitude envelope followers with a
// hold-then-cooldown attack detector for the transient shaper's boost control.
//
// Handshake: a sample is consumed on every cycle where ena & sample_valid is
// high (the accept). There is no ready/backpressure; out_valid is the accept
// delayed by one register stage and marks the cycle the outputs reflect it.
module transient_detector #(
  parameter int WIDTH        = 8,
  parameter int FAST_SHIFT   = 1,
  parameter int SLOW_SHIFT   = 4,
  parameter int HOLD_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] env_fast,
  output logic [WIDTH-1:0] env_slow,
  output logic             attack,
  output logic             attack_pulse,
  output logic             out_valid,
  // FSM state for observation: 0 = IDLE, 1 = ATTACK, 2 = COOLDOWN
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(HOLD_SAMPLES + 1);

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    HOLD_LD  = CW'(HOLD_SAMPLES);
  localparam logic [CW-1:0]    ONE_CW   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_COOL   = 2'd2
  } state_t;

  // One smoothing step: move env toward mag by (mag-env)>>>shift, but never
  // by zero while a difference remains, so the envelope settles exactly.
  function automatic logic [WIDTH-1:0] env_step(
    input logic [WIDTH-1:0] env,
    input logic [WIDTH-1:0] mag_v,
    input int               shift
  );
    logic signed [WIDTH:0] d;
    logic signed [WIDTH:0] step;
    d    = $signed({1'b0, mag_v}) - $signed({1'b0, env});
    step = d >>> shift;
    if ((d != '0) && (step == '0)) begin
      step = d[WIDTH] ? '1 : {{WIDTH{1'b0}}, 1'b1};
    end
    env_step = env + step[WIDTH-1:0];
  endfunction

  state_t           state_q;
  logic [CW-1:0]    hold_cnt_q;
  logic [WIDTH-1:0] env_fast_q, env_fast_d;
  logic [WIDTH-1:0] env_slow_q, env_slow_d;
  logic             attack_q;
  logic             attack_pulse_q;
  logic             out_valid_q;

  logic             accept;
  logic [WIDTH-1:0] mag;
  logic signed [WIDTH:0] diff;
  logic             trigger;
  logic             cool_ok;

  assign accept = ena & sample_valid;

  // Saturating absolute value: the most negative code maps to the largest positive.
  always_comb begin
    mag = sample_in;
    if (sample_in[WIDTH-1]) begin
      if (sample_in == MIN_NEG) begin
        mag = MAX_POS;
      end else begin
        mag = (~sample_in) + ONE_W;
      end
    end
  end

  // Next envelopes and detector decisions, all based on the post-update values.
  always_comb begin
    env_fast_d = env_step(env_fast_q, mag, FAST_SHIFT);
    env_slow_d = env_step(env_slow_q, mag, SLOW_SHIFT);
    diff       = $signed({1'b0, env_fast_d}) - $signed({1'b0, env_slow_d});
    trigger    = diff > $signed({1'b0, thresh});
    cool_ok    = diff <= $signed({2'b00, thresh[WIDTH-1:1]});
  end

  // Envelope registers advance only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_fast_q <= '0;
      env_slow_q <= '0;
    end else if (accept) begin
      env_fast_q <= env_fast_d;
      env_slow_q <= env_slow_d;
    end
  end

  // Detector FSM with registered attack/pulse/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hold_cnt_q     <= '0;
      attack_q       <= 1'b0;
      attack_pulse_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      out_valid_q    <= accept;
      attack_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && trigger) begin
            state_q        <= ST_ATTACK;
            hold_cnt_q     <= HOLD_LD;
            attack_q       <= 1'b1;
            attack_pulse_q <= 1'b1;
          end
        end
        ST_ATTACK: begin
          // Retriggers are ignored here; the hold runs out on its own.
          if (accept) begin
            if (hold_cnt_q <= ONE_CW) begin
              state_q    <= ST_COOL;
              hold_cnt_q <= '0;
              attack_q   <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q - ONE_CW;
            end
          end
        end
        ST_COOL: begin
          if (accept && cool_ok) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
          attack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign env_fast     = env_fast_q;
  assign env_slow     = env_slow_q;
  assign attack       = attack_q;
  assign attack_pulse = attack_pulse_q;
  assign out_valid    = out_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_transient_detector.sv
// Bench for transient_detector: directed scenarios with literal expectations
// plus a long randomized run, all checked against an integer reference model.
module tb_transient_detector;

  localparam int W    = 8;
  localparam int FS   = 1;
  localparam int SS   = 4;
  localparam int HOLD = 8;
  localparam int OW   = 2 * W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n        = 1'b0;
  logic         ena          = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_in    = '0;
  logic [W-1:0] thresh       = '0;
  logic [W-1:0] env_fast;
  logic [W-1:0] env_slow;
  logic         attack;
  logic         attack_pulse;
  logic         out_valid;
  logic [1:0]   dbg_state;

  transient_detector #(
    .WIDTH(W), .FAST_SHIFT(FS), .SLOW_SHIFT(SS), .HOLD_SAMPLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid),
    .sample_in(sample_in), .thresh(thresh),
    .env_fast(env_fast), .env_slow(env_slow), .attack(attack),
    .attack_pulse(attack_pulse), .out_valid(out_valid), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_q[$];

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 attack (rem accepts left), 2 cooldown
  int m_f, m_s, m_mode, m_rem;
  int m_att, m_pulse, m_ov;

  function automatic int env_upd(int env, int mag, int sh);
    int d, p, q;
    d = mag - env;
    if (d == 0) return env;
    p = 1 << sh;
    if (d > 0) q = d / p;
    else       q = -((-d + p - 1) / p);   // floor division
    if (q == 0) q = (d > 0) ? 1 : -1;
    return env + q;
  endfunction

  task automatic model_reset();
    m_f = 0; m_s = 0; m_mode = 0; m_rem = 0;
    m_att = 0; m_pulse = 0; m_ov = 0;
  endtask

  task automatic model_step(bit r, bit e, bit v, int s, int th);
    int mag, diff;
    if (!r) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    m_ov    = (e && v) ? 1 : 0;
    if (m_ov == 1) begin
      mag = (s < 0) ? -s : s;
      if (mag > (1 << (W - 1)) - 1) mag = (1 << (W - 1)) - 1;
      m_f  = env_upd(m_f, mag, FS);
      m_s  = env_upd(m_s, mag, SS);
      diff = m_f - m_s;
      if (m_mode == 0) begin
        if (diff > th) begin
          m_mode = 1; m_rem = HOLD; m_pulse = 1;
        end
      end else if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) m_mode = 2;
      end else begin
        if (diff <= th / 2) m_mode = 0;
      end
    end
    m_att = (m_mode == 1) ? 1 : 0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(bit r, bit e, bit v, int s, int th);
    logic [OW-1:0] w;
    @(negedge clk);
    rst_n        = r;
    ena          = e;
    sample_valid = v;
    sample_in    = s[W-1:0];
    thresh       = th[W-1:0];
    model_step(r, e, v, s, th);
    w = {m_f[W-1:0], m_s[W-1:0], m_att[0], m_pulse[0], m_ov[0], m_mode[1:0]};
    exp_q.push_back(w);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("env_fast", env_fast, e[2*W+4:W+5]);
        check("env_slow", env_slow, e[W+4:5]);
        check("attack", attack, e[4]);
        check("attack_pulse", attack_pulse, e[3]);
        check("out_valid", out_valid, e[2]);
        check("state", dbg_state, e[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit r, e, v;
    int s, th;

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_env_fast", env_fast, 0);
    check("rst_env_slow", env_slow, 0);
    check("rst_attack", attack, 0);
    check("rst_pulse", attack_pulse, 0);
    check("rst_out_valid", out_valid, 0);

    // Impulse, hold and cooldown
    cycle(1, 1, 1, 100, 16);
    settle();
    check("imp_env_fast", env_fast, 50);
    check("imp_env_slow", env_slow, 6);
    check("imp_attack", attack, 1);
    check("imp_pulse", attack_pulse, 1);
    check("imp_out_valid", out_valid, 1);
    for (int i = 0; i < 7; i++) cycle(1, 1, 1, 0, 16);
    settle();
    check("hold_8th_attack", attack, 1);
    check("hold_8th_pulse", attack_pulse, 0);
    cycle(1, 1, 1, 0, 16);
    settle();
    check("hold_end_attack", attack, 0);
    check("hold_end_state", dbg_state, 2);
    cycle(1, 1, 1, 0, 16);
    settle();
    check("cool_exit_state", dbg_state, 0);

    // Negative saturation and exact convergence
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, -128, 16);
    settle();
    check("sat_env_fast", env_fast, 63);
    check("sat_env_slow", env_slow, 7);
    for (int i = 0; i < 200; i++) cycle(1, 1, 1, 64, 16);
    settle();
    check("conv_env_fast", env_fast, 64);
    check("conv_env_slow", env_slow, 64);
    check("conv_attack", attack, 0);

    // Gating mid-attack
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 100, 16);
    cycle(1, 1, 1, 0, 16);
    cycle(1, 1, 1, 0, 16);
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 1'($urandom_range(1)), int'($urandom_range(255)) - 128, 16);
    settle();
    check("gate_env_fast", env_fast, 12);
    check("gate_env_slow", env_slow, 4);
    check("gate_attack", attack, 1);
    check("gate_out_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 16);
    settle();
    check("gate_resume_attack", attack, 1);
    cycle(1, 1, 1, 0, 16);
    settle();
    check("gate_end_attack", attack, 0);

    // Asynchronous reset mid-attack
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 100, 16);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_env_fast", env_fast, 0);
    check("arst_env_slow", env_slow, 0);
    check("arst_attack", attack, 0);
    check("arst_pulse", attack_pulse, 0);
    check("arst_out_valid", out_valid, 0);
    model_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 100, 16);
    settle();
    check("arst_imp_env_fast", env_fast, 50);
    check("arst_imp_env_slow", env_slow, 6);
    check("arst_imp_pulse", attack_pulse, 1);

    // Threshold edge: diff == thresh does not trigger, thresh+1 does
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 44, 20);
    settle();
    check("thr_eq_env_fast", env_fast, 22);
    check("thr_eq_env_slow", env_slow, 2);
    check("thr_eq_attack", attack, 0);
    check("thr_eq_pulse", attack_pulse, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 46, 20);
    settle();
    check("thr_gt_attack", attack, 1);
    check("thr_gt_pulse", attack_pulse, 1);
    cycle(1, 1, 1, 46, 20);
    settle();
    check("thr_gt_pulse_once", attack_pulse, 0);
    check("thr_gt_attack_hold", attack, 1);

    // Randomized run
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(299) != 0);
      e  = ($urandom_range(9) != 0);
      v  = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) s = int'($urandom_range(255)) - 128;
      else                        s = int'($urandom_range(20)) - 10;
      th = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(40));
      cycle(r, e, v, s, th);
    end
    settle();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
